// File: rtl/uart_boot_loader.sv
// Framed UART firmware loader feeding the boot RAM write port; holds the CPU in reset during a load.
// Optional inter-byte timeout is enabled by defining UART_BOOT_LOADER_TIMEOUT_EN.
module uart_boot_loader #(
    parameter int          ADDR_W         = 11,
    parameter int          DEPTH          = 2048,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W+1:0]   cnt_q, cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [3:0]          be_d;
    logic [31:0]         data_d;
    logic                wren_d, cpu_d, busy_d, done_d, err_d;
    logic                last_byte;

`ifdef UART_BOOT_LOADER_TIMEOUT_EN
    logic [31:0]         tmo_q, tmo_d;
`else
    logic [31:0]         unused_tmo_cfg;
    assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // Counter is ADDR_W+2 bits; widen to 18 so LEN=DEPTH compares correctly without wrap.
    assign last_byte = (({{(16-ADDR_W){1'b0}}, cnt_q} + 18'd1) == {len_q, 2'b00});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            mem_address <= '0;
            mem_byteena <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            cpu_reset   <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            mem_address <= addr_d;
            mem_byteena <= be_d;
            mem_data    <= data_d;
            mem_wren    <= wren_d;
            cpu_reset   <= cpu_d;
            busy        <= busy_d;
            load_done   <= done_d;
            load_error  <= err_d;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        addr_d   = mem_address;
        be_d     = mem_byteena;
        data_d   = mem_data;
        wren_d   = 1'b0;
        cpu_d    = cpu_reset;
        busy_d   = busy;
        done_d   = load_done;
        err_d    = load_error;
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
        if (rx_valid || state_q == IDLE) tmo_d = '0;
        else                             tmo_d = tmo_q + 32'd1;
`endif

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        cpu_d   = 1'b1;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = LEN_LO;
                    end
                end
                LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    len_d = {rx_data, len_lo_q};
                    if ({1'b0, rx_data, len_lo_q} > DEPTH_L) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        cpu_d   = 1'b1;
                        state_d = IDLE;
                    end else if ({rx_data, len_lo_q} == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    addr_d = cnt_q[ADDR_W+1:2];
                    be_d   = 4'b0001 << cnt_q[1:0];
                    data_d = {4{rx_data}};
                    wren_d = 1'b1;
                    sum_d  = sum_q + rx_data;
                    cnt_d  = cnt_q + 1'b1;
                    if (last_byte) state_d = CSUM;
                end
                CSUM: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (rx_data == sum_q) begin
                        done_d = 1'b1;
                        cpu_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                        cpu_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
        else if (state_q != IDLE && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            cpu_d   = 1'b1;
            state_d = IDLE;
        end
`endif
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected RAM writes are queued, a monitor checks each wren.
module tb_uart_boot_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        cpu_reset;
    logic        busy;
    logic        load_done;
    logic        load_error;

    typedef struct packed {
        logic [10:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    wr_t expq[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clock = ~clock;

    uart_boot_loader #(
        .ADDR_W(11),
        .DEPTH(2048),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .mem_address(mem_address),
        .mem_byteena(mem_byteena),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .cpu_reset(cpu_reset),
        .busy(busy),
        .load_done(load_done),
        .load_error(load_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Status nibble order: {cpu_reset, busy, load_done, load_error}
    task automatic st(input string name, input logic [3:0] exp);
        chk(name, {28'd0, cpu_reset, busy, load_done, load_error}, {28'd0, exp});
    endtask

    task automatic pw(input logic [10:0] a, input logic [3:0] be, input logic [7:0] b);
        wr_t e;
        e.a  = a;
        e.be = be;
        e.d  = {4{b}};
        expq.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic frame1();
        pw(11'd0, 4'h1, 8'h11); pw(11'd0, 4'h2, 8'h22);
        pw(11'd0, 4'h4, 8'h33); pw(11'd0, 4'h8, 8'h44);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    endtask

    always @(negedge clock) begin
        if (mem_wren === 1'b1) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%h be=%h data=%h want no write",
                         mem_address, mem_byteena, mem_data);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if ({mem_address, mem_byteena, mem_data} !== e) begin
                    bad++;
                    $display("FAIL ram_write: got addr=%h be=%h data=%h want addr=%h be=%h data=%h",
                             mem_address, mem_byteena, mem_data, e.a, e.be, e.d);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        st("reset_status", 4'b0000);
        chk("reset_wren", {31'd0, mem_wren}, 32'd0);
        chk("reset_addr", {21'd0, mem_address}, 32'd0);
        chk("reset_be", {28'd0, mem_byteena}, 32'd0);
        chk("reset_data", mem_data, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // good single-word frame
        pw(11'd0, 4'h1, 8'h11); pw(11'd0, 4'h2, 8'h22);
        pw(11'd0, 4'h4, 8'h33); pw(11'd0, 4'h8, 8'h44);
        send(8'hA5);
        st("t1_after_sync", 4'b1100);
        send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        st("t1_before_csum", 4'b1100);
        send(8'hAA);
        st("t1_done", 4'b0010);

        // bad checksum, then a good frame clears the error
        frame1();
        send(8'hAB);
        st("t2_error", 4'b1001);
        send(8'hA5);
        st("t2_sync_clears", 4'b1100);
        pw(11'd0, 4'h1, 8'h01); pw(11'd0, 4'h2, 8'h02);
        pw(11'd0, 4'h4, 8'h03); pw(11'd0, 4'h8, 8'h04);
        send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0A);
        st("t2_recover", 4'b0010);

        // zero length and oversize length
        send(8'hA5); send(8'h00); send(8'h00);
        st("t3_len0_in_csum", 4'b1100);
        send(8'h00);
        st("t3_len0_done", 4'b0010);
        send(8'hA5); send(8'h01); send(8'h08);
        st("t3_len2049_err", 4'b1001);
        repeat (3) @(negedge clock);
        st("t3_err_sticky", 4'b1001);

        // junk before sync, A5 inside data, two words back-to-back
        send(8'h00); send(8'hFF);
        st("t4_junk_ignored", 4'b1001);
        pw(11'd0, 4'h1, 8'hA5); pw(11'd0, 4'h2, 8'hA5);
        pw(11'd0, 4'h4, 8'h00); pw(11'd0, 4'h8, 8'h01);
        pw(11'd1, 4'h1, 8'h10); pw(11'd1, 4'h2, 8'h20);
        pw(11'd1, 4'h4, 8'h30); pw(11'd1, 4'h8, 8'h40);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'hA5); send(8'hA5); send(8'h00); send(8'h01);
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        st("t4_before_csum", 4'b1100);
        send(8'hEB);
        st("t4_done", 4'b0010);

        // reset mid-frame, then full reload
        pw(11'd0, 4'h1, 8'hDE); pw(11'd0, 4'h2, 8'hAD); pw(11'd0, 4'h4, 8'hBE);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE);
        @(negedge clock);
        reset = 1'b1;
        #1;
        st("t5_reset_status", 4'b0000);
        chk("t5_reset_wren", {31'd0, mem_wren}, 32'd0);
        chk("t5_reset_addr", {21'd0, mem_address}, 32'd0);
        chk("t5_reset_be", {28'd0, mem_byteena}, 32'd0);
        chk("t5_reset_data", mem_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        frame1();
        send(8'hAA);
        st("t5_reload_done", 4'b0010);
        chk("queue_drained", expq.size(), 32'd0);

        // truncated frame after LEN_HI
        send(8'hA5); send(8'h01); send(8'h00);
        repeat (150) @(negedge clock);
`ifdef UART_BOOT_LOADER_TIMEOUT_EN
        st("t6_timeout_err", 4'b1001);
`else
        st("t6_still_busy", 4'b1100);
`endif
        chk("t6_no_writes", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
